// File: rtl/seq_shift_left.sv
// Multi-cycle logical shift-left unit: Y = A << n, computed STEP bits per clock.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; Y holds the last completed result
// SHIFT | shifting the latched operand, up to STEP positions per cycle
// DONE  | result presented on Y; waiting for result_ready
module seq_shift_left #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] n,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [WIDTH-1:0]   Y,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // STEP is always below WIDTH, so it fits in the shift-amount width.
    localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]   y_q, y_d;

    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   data_shifted;
    logic [SHAMT_W-1:0] count_left;

    // Next-state, datapath and handshake outputs.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        count_d      = count_q;
        y_d          = y_q;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        k            = '0;
        data_shifted = data_q;
        count_left   = count_q;

        case (state_q)
            S_IDLE: begin
                // Held low during reset so a request coinciding with rst is never accepted.
                start_ready = !rst;
                if (start_valid) begin
                    data_d  = A;
                    count_d = n;
                    if (n == '0) begin
                        y_d     = A;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                busy         = 1'b1;
                k            = (count_q < STEP_C) ? count_q : STEP_C;
                data_shifted = data_q << k;
                count_left   = count_q - k;
                data_d       = data_shifted;
                count_d      = count_left;
                if (count_left == '0) begin
                    y_d     = data_shifted;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            count_q <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            y_q     <= y_d;
        end
    end

    assign Y = y_q;

endmodule

// File: tb/tb_seq_shift_left.sv
// Bench for seq_shift_left: one instance per legal STEP, all sharing the same stimulus.
module tb_seq_shift_left;

    localparam int NS = 5;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        result_ready;
    logic [31:0] A;
    logic [4:0]  n;

    logic        sr [NS];
    logic        rv [NS];
    logic        bz [NS];
    logic [31:0] y  [NS];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NS; g++) begin : g_dut
        seq_shift_left #(
            .WIDTH  (32),
            .SHAMT_W(5),
            .STEP   (1 << g)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start_valid (start_valid),
            .start_ready (sr[g]),
            .A           (A),
            .n           (n),
            .result_valid(rv[g]),
            .result_ready(result_ready),
            .Y           (y[g]),
            .busy        (bz[g])
        );
    end

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, 1 << idx, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: Y is the plain truncated left shift; latency is one cycle plus ceil(n/STEP).
    function automatic int exp_lat(input int idx, input int nn);
        int step;
        step = 1 << idx;
        return 1 + (nn + step - 1) / step;
    endfunction

    // Issue one request at a negedge, then watch every instance until it has
    // delivered (and, with result_ready high, returned to idle).
    task automatic run_txn(input logic [31:0] a, input logic [4:0] nn, input logic rr);
        int          lat [NS];
        logic [31:0] yv  [NS];
        logic [31:0] ey;
        bit          done;
        ey = a << nn;
        for (int g = 0; g < NS; g++) begin
            lat[g] = 0;
            yv[g]  = '0;
            chk("ready_before_req", g, 32'(sr[g]), 32'd1);
        end
        A            = a;
        n            = nn;
        start_valid  = 1'b1;
        result_ready = rr;
        cycle();
        start_valid = 1'b0;
        A           = $urandom;
        n           = 5'($urandom);
        for (int t = 1; t <= 40; t++) begin
            done = 1'b1;
            for (int g = 0; g < NS; g++) begin
                if (lat[g] == 0 && rv[g] === 1'b1) begin
                    lat[g] = t;
                    yv[g]  = y[g];
                end else if (rr && lat[g] != 0 && t == lat[g] + 1) begin
                    chk("busy_after_hs", g, 32'(bz[g]), 32'd0);
                    chk("valid_after_hs", g, 32'(rv[g]), 32'd0);
                end
                if (lat[g] == 0 || (rr && t <= lat[g])) done = 1'b0;
            end
            if (done) break;
            cycle();
        end
        for (int g = 0; g < NS; g++) begin
            chk("latency", g, 32'(lat[g]), 32'(exp_lat(g, int'(nn))));
            chk("result", g, yv[g], ey);
        end
    endtask

    initial begin
        logic [31:0] ey;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        start_valid  = 1'b1;
        result_ready = 1'b0;
        A            = 32'hFFFF_FFFF;
        n            = 5'd3;
        @(negedge clk);

        // Reset held with a pending request: nothing accepted, everything quiet.
        repeat (3) begin
            cycle();
            for (int g = 0; g < NS; g++) begin
                chk("rst_ready", g, 32'(sr[g]), 32'd0);
                chk("rst_busy", g, 32'(bz[g]), 32'd0);
                chk("rst_valid", g, 32'(rv[g]), 32'd0);
            end
        end
        start_valid = 1'b0;
        rst         = 1'b0;
        #1;
        for (int g = 0; g < NS; g++) begin
            chk("post_rst_ready", g, 32'(sr[g]), 32'd1);
            chk("post_rst_y", g, y[g], 32'd0);
            chk("post_rst_valid", g, 32'(rv[g]), 32'd0);
            chk("post_rst_busy", g, 32'(bz[g]), 32'd0);
        end
        @(negedge clk);

        // Directed shifts: full-range, zero shift, saturating and nibble shifts.
        run_txn(32'h0000_0001, 5'd31, 1'b1);
        run_txn(32'hDEAD_BEEF, 5'd0, 1'b1);
        run_txn(32'hFFFF_FFFF, 5'd7, 1'b1);
        run_txn(32'h1234_5678, 5'd4, 1'b1);

        // Backpressure: result held while inputs wiggle.
        run_txn(32'hCAFE_F00D, 5'd9, 1'b0);
        ey = 32'hCAFE_F00D << 9;
        for (int i = 0; i < 10; i++) begin
            start_valid = (i % 2 == 0);
            A           = $urandom;
            n           = 5'($urandom);
            cycle();
            for (int g = 0; g < NS; g++) begin
                chk("bp_y", g, y[g], ey);
                chk("bp_valid", g, 32'(rv[g]), 32'd1);
                chk("bp_ready", g, 32'(sr[g]), 32'd0);
            end
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        cycle();
        for (int g = 0; g < NS; g++) begin
            chk("bp_release_valid", g, 32'(rv[g]), 32'd0);
            chk("bp_release_ready", g, 32'(sr[g]), 32'd1);
            chk("bp_release_busy", g, 32'(bz[g]), 32'd0);
            chk("bp_y_kept", g, y[g], ey);
        end
        run_txn(32'h8000_0003, 5'd1, 1'b1);

        // Reset in the middle of a long shift discards the request.
        result_ready = 1'b0;
        A            = 32'h0F0F_0F0F;
        n            = 5'd20;
        start_valid  = 1'b1;
        cycle();
        start_valid = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            chk("mid_busy", 0, 32'(bz[0]), 32'd1);
            chk("mid_valid", 0, 32'(rv[0]), 32'd0);
            if (t < 4) cycle();
        end
        rst = 1'b1;
        cycle();
        for (int g = 0; g < NS; g++) begin
            chk("mid_rst_busy", g, 32'(bz[g]), 32'd0);
            chk("mid_rst_valid", g, 32'(rv[g]), 32'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            cycle();
            for (int g = 0; g < NS; g++) chk("mid_rst_quiet", g, 32'(rv[g]), 32'd0);
        end
        run_txn(32'h0000_0003, 5'd1, 1'b1);

        // Random operands and shift amounts against the reference model.
        repeat (2000) begin
            run_txn($urandom, 5'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_shift_left.md
Name: seq_shift_left

Overview:
- Multi-cycle logical shift-left unit for the ALU/coprocessor path. It is the left-direction counterpart of the combinational arithmetic right shifter.
- Accepts an operand and shift amount through a valid/ready request port.
- Shifts STEP bit positions per clock, filling with zeros.
- Returns Y = A << n through a valid/ready result port.
- Intended for area-constrained configurations where a full barrel shifter is too costly.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width. Must equal clog2(WIDTH).
- STEP, 1, maximum bit positions shifted per cycle. Legal values are 1, 2, 4, 8 and 16; STEP must be less than WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start_valid  input  1  request valid
- start_ready  output  1  unit can accept a request
- A  input  WIDTH  operand, sampled on accept
- n  input  SHAMT_W  shift amount, unsigned, sampled on accept
- result_valid  output  1  Y holds a completed result
- result_ready  input  1  consumer takes the result
- Y  output  WIDTH  shift result, registered
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Interface timing: one clock, clk. Reset rst is synchronous and active-high. No asynchronous logic.
- Reset values: state=IDLE, data reg=0, count=0, Y=0, result_valid=0, busy=0. start_ready=0 while rst is high, then 1 from the first cycle after reset deasserts.
- Accept: a request is accepted on a rising edge where start_valid && start_ready. A and n are latched on that edge. A and n are don't-care on all other cycles.
- State IDLE:
  - start_ready=1, busy=0, result_valid=0.
  - On accept: data=A, count=n.
  - Next state is DONE if n==0, otherwise SHIFT.
- State SHIFT:
  - start_ready=0, busy=1.
  - Each cycle: k=min(count,STEP); data=data<<k (zero-fill, bits shifted past the MSB are discarded); count=count-k.
  - When the updated count==0, next state is DONE.
- State DONE:
  - result_valid=1, busy=1, start_ready=0, Y=data.
  - Y and result_valid hold stable until result_ready is high on a rising edge; then next state is IDLE and result_valid drops.
- Latency: result_valid is first high at (accept edge) + 1 + ceil(n/STEP) cycles.
  - n=0: one cycle.
  - STEP=1, n=31: 32 cycles.
- Throughput:
  - No overlap between requests. The earliest next accept is the cycle after the result handshake.
  - start_valid in SHIFT or DONE is ignored and not queued.
- Arithmetic: the result is a pure logical left shift, bit-identical to (A << n) truncated to WIDTH. No sign handling; n is never negative.
- Backpressure: result_ready may be held low indefinitely. Y must not change while result_valid=1.
- result_ready while result_valid=0 has no effect.
- Reset mid-operation: rst in SHIFT or DONE forces IDLE on that edge. The in-flight result is discarded; no result_valid pulse occurs.
- Simultaneous rst and start_valid: reset wins and no request is accepted.
- Y stays at its last completed value in IDLE and SHIFT. It is updated only on entry to DONE.

Test Plan:
- Reset then idle: assert rst 3 cycles with start_valid=1 -> no accept. After release: start_ready=1, Y=0, result_valid=0, busy=0.
- STEP=1, A=0x00000001, n=31, result_ready=1 -> result_valid at accept+32, Y=0x80000000, busy low the cycle after the handshake.
- Zero shift: A=0xDEADBEEF, n=0 -> result_valid at accept+1, Y=0xDEADBEEF.
- STEP=4, A=0xFFFFFFFF, n=7 -> result_valid at accept+3, Y=0xFFFFFF80. Also A=0x12345678, n=4 -> accept+2, Y=0x23456780.
- Backpressure: after completion hold result_ready=0 for 10 cycles while toggling start_valid and A -> Y, result_valid and start_ready=0 all stable. Raise result_ready -> IDLE next cycle. A new request is accepted the following cycle.
- Reset mid-shift: STEP=1, n=20, assert rst at accept+5 -> IDLE next edge, no result_valid. A fresh A=0x3, n=1 then yields Y=0x6.
- Random: 2000 random (A,n) for each STEP value compared against the A<<n reference model, checking both result and latency.
